fm_wm_product_unit: RTL

- Computes the GCN combination product FM×WM one output element per cycle.
- Sequences weight-column and feature-row reads by driving the feature read counter's enables and the `weight_count` index.
- Consumes the synchronous memory read data, forms 96-element dot products in a 2-stage pipeline, and writes each result with its row/column tag toward the FM_WM product store.
- Sits directly downstream of the feature/weight read-address generation.

---
 rtl/gcn_pkg.sv | 29 ++
 rtl/fm_wm_product_unit_if.sv | 45 ++++
 rtl/fm_wm_product_unit_dot_product_pipe.sv | 84 ++++++++
 rtl/fm_wm_product_unit.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/gcn_pkg.sv
// Shared dimensions, width helpers and FSM encoding for the GCN combination
// datapath (feature matrix x weight matrix product).
package gcn_pkg;

  localparam int FEATURE_ROWS_DEF = 6;
  localparam int FEATURE_COLS_DEF = 96;
  localparam int WEIGHT_COLS_DEF  = 3;
  localparam int DATA_WIDTH_DEF   = 5;
  localparam int WEIGHT_COUNT_W   = 5;
  localparam int DRAIN_CYCLES     = 3;

  // Dot-product width: a full-scale element product plus enough headroom for
  // summing every element of a row, so the reduction can never overflow.
  function automatic int prod_width(input int data_width, input int elems);
    return 2 * data_width + $clog2(elems);
  endfunction

  localparam int PROD_WIDTH_DEF = prod_width(DATA_WIDTH_DEF, FEATURE_COLS_DEF);

  typedef enum logic [2:0] {
    IDLE,
    READ_W,
    LOAD_W,
    READ_F,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/fm_wm_product_unit_if.sv
// Bus bundle of the FM x WM product unit: start/done control, the memory read
// side and the tagged product write toward the FM_WM store.
interface fm_wm_product_unit_if
  import gcn_pkg::*;
#(
  parameter int FEATURE_ROWS = FEATURE_ROWS_DEF,
  parameter int FEATURE_COLS = FEATURE_COLS_DEF,
  parameter int WEIGHT_COLS  = WEIGHT_COLS_DEF,
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int PROD_WIDTH   = prod_width(DATA_WIDTH, FEATURE_COLS)
);

  localparam int ROW_W = $clog2(FEATURE_ROWS);
  localparam int COL_W = $clog2(WEIGHT_COLS);

  logic                               start;
  logic                               done;
  logic [FEATURE_COLS*DATA_WIDTH-1:0] read_data;
  logic                               enable_read;
  logic                               read_feature_or_weight;
  logic                               enable_scratch_pad;
  logic                               enable_feature_counter;
  logic                               enable_write_fm_wm_prod;
  logic [WEIGHT_COUNT_W-1:0]          weight_count;
  logic                               fm_wm_wr_en;
  logic [ROW_W-1:0]                   fm_wm_wr_row;
  logic [COL_W-1:0]                   fm_wm_wr_col;
  logic [PROD_WIDTH-1:0]              fm_wm_wr_data;

  // The product unit masters both the read strobes and the product writes.
  modport master (
    input  start, read_data,
    output done, enable_read, read_feature_or_weight, enable_scratch_pad,
           enable_feature_counter, enable_write_fm_wm_prod, weight_count,
           fm_wm_wr_en, fm_wm_wr_row, fm_wm_wr_col, fm_wm_wr_data
  );

  modport slave (
    output start, read_data,
    input  done, enable_read, read_feature_or_weight, enable_scratch_pad,
           enable_feature_counter, enable_write_fm_wm_prod, weight_count,
           fm_wm_wr_en, fm_wm_wr_row, fm_wm_wr_col, fm_wm_wr_data
  );

endinterface

// File: rtl/fm_wm_product_unit_dot_product_pipe.sv
// Two-stage dot-product pipeline: element products registered in stage 1,
// their sum registered in stage 2, with the row/column tag riding alongside.
module dot_product_pipe #(
  parameter int FEATURE_COLS = 96,
  parameter int DATA_WIDTH   = 5,
  parameter int PROD_WIDTH   = 17,
  parameter int ROW_W        = 3,
  parameter int COL_W        = 2
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               issue_valid,
  input  logic [ROW_W-1:0]                   issue_row,
  input  logic [COL_W-1:0]                   issue_col,
  input  logic [FEATURE_COLS*DATA_WIDTH-1:0] feature_data,
  input  logic [FEATURE_COLS*DATA_WIDTH-1:0] weight_data,
  output logic                               out_valid,
  output logic [ROW_W-1:0]                   out_row,
  output logic [COL_W-1:0]                   out_col,
  output logic [PROD_WIDTH-1:0]              out_data
);

  localparam int MUL_W = 2 * DATA_WIDTH;

  // Stage 0 marks the cycle the memory word for an issued read is on the bus.
  logic             v0_q, v1_q;
  logic [ROW_W-1:0] row0_q, row1_q;
  logic [COL_W-1:0] col0_q, col1_q;
  logic [MUL_W-1:0] prod_q [FEATURE_COLS];
  logic [PROD_WIDTH-1:0] sum_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v0_q   <= 1'b0;
      v1_q   <= 1'b0;
      row0_q <= '0;
      row1_q <= '0;
      col0_q <= '0;
      col1_q <= '0;
    end else begin
      v0_q   <= issue_valid;
      v1_q   <= v0_q;
      row0_q <= issue_row;
      col0_q <= issue_col;
      row1_q <= row0_q;
      col1_q <= col0_q;
    end
  end

  // NOTE: the product array carries no reset; it only loads under a valid, so
  // stale contents can never reach the output after a reset.
  always_ff @(posedge clk) begin
    if (v0_q) begin
      for (int i = 0; i < FEATURE_COLS; i++) begin
        prod_q[i] <= MUL_W'(feature_data[i*DATA_WIDTH +: DATA_WIDTH]) *
                     MUL_W'(weight_data[i*DATA_WIDTH +: DATA_WIDTH]);
      end
    end
  end

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < FEATURE_COLS; i++) begin
      sum_c = sum_c + PROD_WIDTH'(prod_q[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_row   <= '0;
      out_col   <= '0;
      out_data  <= '0;
    end else begin
      out_valid <= v1_q;
      if (v1_q) begin
        out_row  <= row1_q;
        out_col  <= col1_q;
        out_data <= sum_c;
      end
    end
  end

endmodule

// File: rtl/fm_wm_product_unit.sv
// FM x WM product unit: sequences weight-column and feature-row reads and
// streams one tagged dot product per cycle toward the FM_WM product store.
module fm_wm_product_unit
  import gcn_pkg::*;
#(
  parameter int FEATURE_ROWS = FEATURE_ROWS_DEF,
  parameter int FEATURE_COLS = FEATURE_COLS_DEF,
  parameter int WEIGHT_COLS  = WEIGHT_COLS_DEF,
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int PROD_WIDTH   = prod_width(DATA_WIDTH, FEATURE_COLS)
) (
  input  logic                 clk,
  input  logic                 reset,
  fm_wm_product_unit_if.master bus
);

  localparam int ROW_W = $clog2(FEATURE_ROWS);
  localparam int COL_W = $clog2(WEIGHT_COLS);

  localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(FEATURE_ROWS - 1);
  localparam logic [COL_W-1:0] COL_LAST   = COL_W'(WEIGHT_COLS - 1);
  localparam logic [1:0]       DRAIN_LAST = 2'(DRAIN_CYCLES - 1);

  state_t           state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] wcol_q, wcol_d;
  logic [1:0]       drain_q, drain_d;
  logic             issue_valid;

  logic [FEATURE_COLS*DATA_WIDTH-1:0] weight_buf_q;

  // NOTE: sequential state uses non-blocking assignments so every flop sees
  // the pre-edge value of every other flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      row_q   <= '0;
      wcol_q  <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      wcol_q  <= wcol_d;
      drain_q <= drain_d;
    end
  end

  // NOTE: every signal gets a default before the case so no path can infer a
  // latch.
  always_comb begin
    state_d                     = state_q;
    row_d                       = row_q;
    wcol_d                      = wcol_q;
    drain_d                     = drain_q;
    issue_valid                 = 1'b0;
    bus.enable_read             = 1'b0;
    bus.read_feature_or_weight  = 1'b0;
    bus.enable_scratch_pad      = 1'b0;
    bus.enable_feature_counter  = 1'b0;
    bus.enable_write_fm_wm_prod = 1'b0;
    bus.weight_count            = '0;
    bus.done                    = 1'b0;

    unique case (state_q)
      IDLE: begin
        row_d  = '0;
        wcol_d = '0;
        if (bus.start) state_d = READ_W;
      end

      READ_W: begin
        bus.enable_read        = 1'b1;
        bus.enable_scratch_pad = 1'b1;
        bus.weight_count       = WEIGHT_COUNT_W'(wcol_q);
        state_d                = LOAD_W;
      end

      LOAD_W: begin
        bus.weight_count = WEIGHT_COUNT_W'(wcol_q);
        state_d          = READ_F;
      end

      READ_F: begin
        bus.enable_read             = 1'b1;
        bus.read_feature_or_weight  = 1'b1;
        bus.enable_feature_counter  = 1'b1;
        bus.enable_write_fm_wm_prod = 1'b1;
        bus.weight_count            = WEIGHT_COUNT_W'(wcol_q);
        issue_valid                 = 1'b1;
        if (row_q == ROW_LAST) begin
          row_d = '0;
          if (wcol_q < COL_LAST) begin
            wcol_d  = wcol_q + 1'b1;
            state_d = READ_W;
          end else begin
            drain_d = '0;
            state_d = DRAIN;
          end
        end else begin
          row_d = row_q + 1'b1;
        end
      end

      // Wait out the three pipeline stages behind the last feature read.
      DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          wcol_d  = '0;
          state_d = DONE;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end

      DONE: begin
        bus.done = 1'b1;
        wcol_d   = '0;
        state_d  = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // The previous column's last row is multiplied one cycle before this
  // reload, so no stall is needed between columns.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      weight_buf_q <= '0;
    end else if (state_q == LOAD_W) begin
      weight_buf_q <= bus.read_data;
    end
  end

  dot_product_pipe #(
    .FEATURE_COLS (FEATURE_COLS),
    .DATA_WIDTH   (DATA_WIDTH),
    .PROD_WIDTH   (PROD_WIDTH),
    .ROW_W        (ROW_W),
    .COL_W        (COL_W)
  ) u_pipe (
    .clk          (clk),
    .reset        (reset),
    .issue_valid  (issue_valid),
    .issue_row    (row_q),
    .issue_col    (wcol_q),
    .feature_data (bus.read_data),
    .weight_data  (weight_buf_q),
    .out_valid    (bus.fm_wm_wr_en),
    .out_row      (bus.fm_wm_wr_row),
    .out_col      (bus.fm_wm_wr_col),
    .out_data     (bus.fm_wm_wr_data)
  );

endmodule
